// File: rtl/logic_rs.sv
// logic_rs: reservation station for the logic unit with CDB wakeup and an age-ordered registered dispatch stage
module logic_rs #(
  parameter int ENTRIES = 4,
  parameter int TAG_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [1:0]        issue_op,
  input  logic [TAG_W-1:0]  issue_dest,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              issue_vj_ok,
  input  logic              issue_vk_ok,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              fu_valid,
  input  logic              fu_ready,
  output logic [1:0]        fu_op,
  output logic [DATA_W-1:0] fu_in1,
  output logic [DATA_W-1:0] fu_in2,
  output logic [TAG_W-1:0]  fu_dest
);
  localparam int RW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);
  logic [ENTRIES-1:0] busy, vj_ok, vk_ok, ready;
  logic [1:0]         op   [ENTRIES];
  logic [TAG_W-1:0]   dest [ENTRIES];
  logic [TAG_W-1:0]   qj   [ENTRIES];
  logic [TAG_W-1:0]   qk   [ENTRIES];
  logic [DATA_W-1:0]  vj   [ENTRIES];
  logic [DATA_W-1:0]  vk   [ENTRIES];
  logic [RW-1:0]      rank [ENTRIES];
  logic [RW-1:0]      sel, ins_idx, new_rank;
  logic [CW-1:0]      cnt;
  logic               any_ready, dispatch, do_issue, j_byp, k_byp;
  assign ready       = busy & vj_ok & vk_ok;
  assign issue_ready = |(~busy);
  assign dispatch    = any_ready & (~fu_valid | fu_ready) & ~flush;
  assign do_issue    = issue_valid & issue_ready & ~flush;
  assign j_byp       = ~issue_vj_ok & cdb_valid & (cdb_tag == issue_qj);
  assign k_byp       = ~issue_vk_ok & cdb_valid & (cdb_tag == issue_qk);
  // oldest ready entry, lowest free slot, and occupancy from registered state
  always_comb begin
    any_ready = 1'b0;
    sel = '0;
    ins_idx = '0;
    cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready[i] && (!any_ready || rank[i] < rank[sel])) begin
        any_ready = 1'b1;
        sel = RW'(i);
      end
      cnt = cnt + CW'(busy[i]);
    end
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!busy[i]) ins_idx = RW'(i);
    new_rank = RW'(cnt - CW'(dispatch));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      vj_ok <= '0;
      vk_ok <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op[i] <= '0;
        dest[i] <= '0;
        qj[i] <= '0;
        qk[i] <= '0;
        vj[i] <= '0;
        vk[i] <= '0;
        rank[i] <= '0;
      end
      fu_valid <= 1'b0;
      fu_op <= '0;
      fu_in1 <= '0;
      fu_in2 <= '0;
      fu_dest <= '0;
    end else if (flush) begin
      busy <= '0;
      fu_valid <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (dispatch && RW'(i) == sel)
          busy[i] <= 1'b0;
        else if (busy[i]) begin
          if (cdb_valid && !vj_ok[i] && qj[i] == cdb_tag) begin
            vj[i] <= cdb_data;
            vj_ok[i] <= 1'b1;
          end
          if (cdb_valid && !vk_ok[i] && qk[i] == cdb_tag) begin
            vk[i] <= cdb_data;
            vk_ok[i] <= 1'b1;
          end
          if (dispatch && rank[i] > rank[sel]) rank[i] <= rank[i] - RW'(1);
        end else if (do_issue && RW'(i) == ins_idx) begin
          busy[i] <= 1'b1;
          op[i] <= issue_op;
          dest[i] <= issue_dest;
          qj[i] <= issue_qj;
          qk[i] <= issue_qk;
          vj[i] <= j_byp ? cdb_data : issue_vj;
          vk[i] <= k_byp ? cdb_data : issue_vk;
          vj_ok[i] <= issue_vj_ok | j_byp;
          vk_ok[i] <= issue_vk_ok | k_byp;
          rank[i] <= new_rank;
        end
      end
      if (dispatch) begin
        fu_valid <= 1'b1;
        fu_op <= op[sel];
        fu_in1 <= vj[sel];
        fu_in2 <= vk[sel];
        fu_dest <= dest[sel];
      end else if (fu_ready)
        fu_valid <= 1'b0;
    end
  end
endmodule
